// File: rtl/div8_seq.sv
// Sequential 8-bit restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional DIV8_SIGNED_EN: two's-complement operands, sign fix-up folded into the final iteration.
module div8_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [8:0] rem_acc_q, rem_acc_d;
  logic [7:0] quo_acc_q, quo_acc_d;
  logic [7:0] dvd_q, dvd_d;
  logic [7:0] dvs_q, dvs_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] quotient_q, quotient_d;
  logic [7:0] remainder_q, remainder_d;
  logic       dbz_q, dbz_d;

  logic [8:0] r_shift;
  logic [8:0] diff;
  logic [8:0] r_step;
  logic [7:0] q_step;
  logic [7:0] q_fin;
  logic [7:0] r_fin;
  logic [7:0] r_dbz;
  logic [7:0] dvd_cap;
  logic [7:0] dvs_cap;

`ifdef DIV8_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;

  always_comb begin
    dvd_cap = dividend[7] ? (~dividend + 8'd1) : dividend;
    dvs_cap = divisor[7]  ? (~divisor + 8'd1)  : divisor;
    q_fin   = neg_q_q ? (~q_step + 8'd1) : q_step;
    r_fin   = neg_r_q ? (~r_step[7:0] + 8'd1) : r_step[7:0];
    // re-negating the stored magnitude recovers the original dividend, including -128
    r_dbz   = neg_r_q ? (~dvd_q + 8'd1) : dvd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  always_comb begin
    dvd_cap = dividend;
    dvs_cap = divisor;
    q_fin   = q_step;
    r_fin   = r_step[7:0];
    r_dbz   = dvd_q;
  end
`endif

  always_comb begin
    r_shift = {rem_acc_q[7:0], dvd_q[7]};
    diff    = r_shift - {1'b0, dvs_q};
    r_step  = diff[8] ? r_shift : diff;
    q_step  = {quo_acc_q[6:0], ~diff[8]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_acc_d   = rem_acc_q;
    quo_acc_d   = quo_acc_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV8_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          dvd_d     = dvd_cap;
          dvs_d     = dvs_cap;
          rem_acc_d = 9'd0;
          quo_acc_d = 8'd0;
          cnt_d     = 3'd0;
          state_d   = S_RUN;
`ifdef DIV8_SIGNED_EN
          neg_q_d   = dividend[7] ^ divisor[7];
          neg_r_d   = dividend[7];
`endif
        end
      end
      S_RUN: begin
        if (dvs_q == 8'd0) begin
          // zero divisor: spend exactly one busy cycle, then report
          quotient_d  = 8'hFF;
          remainder_d = r_dbz;
          dbz_d       = 1'b1;
          state_d     = S_DONE;
        end else begin
          rem_acc_d = r_step;
          quo_acc_d = q_step;
          dvd_d     = {dvd_q[6:0], 1'b0};
          cnt_d     = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            quotient_d  = q_fin;
            remainder_d = r_fin;
            dbz_d       = 1'b0;
            state_d     = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      rem_acc_q   <= 9'd0;
      quo_acc_q   <= 8'd0;
      dvd_q       <= 8'd0;
      dvs_q       <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= 8'd0;
      remainder_q <= 8'd0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_acc_q   <= rem_acc_d;
      quo_acc_q   <= quo_acc_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
